// File: rtl/debounce_sync_of_verifla.sv
// Synchronizes and debounces a raw bouncing input. The registered ub_level follows the input
// only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
module debounce_sync_of_verifla #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_l,
  input  logic ub_async,
  output logic ub_level,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  // Comparing against the last count value is the same test as cnt+1 == DEBOUNCE_CYCLES,
  // and it cannot overflow the counter width.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], ub_async};
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // ub_level and busy are registered together with the state so that they never glitch.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      ub_level <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        STABLE_LOW: begin
          if (sync_q) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_ONE;
            busy    <= 1'b1;
          end
        end
        CHECK_HIGH: begin
          if (!sync_q) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= STABLE_HIGH;
            cnt_q    <= '0;
            ub_level <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync_q) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_ONE;
            busy    <= 1'b1;
          end
        end
        CHECK_LOW: begin
          // A sample back at the stable value wins even on the final count cycle.
          if (sync_q) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= STABLE_LOW;
            cnt_q    <= '0;
            ub_level <= 1'b0;
            busy     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q  <= STABLE_LOW;
          cnt_q    <= '0;
          ub_level <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync_of_verifla.sv
// Directed bench for debounce_sync_of_verifla with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_debounce_sync_of_verifla;

  logic clk;
  logic rst_l;
  logic ub_async;
  logic ub_level;
  logic busy;

  int n_checks;
  int n_errors;

  debounce_sync_of_verifla #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .ub_async(ub_async),
    .ub_level(ub_level),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic lvl_exp, input logic busy_exp);
    chk({tag, "_level"}, ub_level, lvl_exp);
    chk({tag, "_busy"}, busy, busy_exp);
  endtask

  // Settle the input at a value for a number of edges and confirm the resulting quiet level.
  task automatic settle(input string tag, input logic val);
    ub_async = val;
    repeat (8) tick();
    chk_both(tag, val, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_l    = 1'b0;
    ub_async = 1'b0;

    // Test 1: reset, then input low for 20 cycles.
    #12;
    chk_both("t1_in_reset", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_both($sformatf("t1_low_c%0d", k), 1'b0, 1'b0);
    end

    // Test 2: clean rise; busy on E2..E4, level on E5.
    ub_async = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk_both($sformatf("t2_E%0d", k), (k >= 5), (k >= 2 && k <= 4));
    end

    // Test 5: clean fall, then immediate re-rise.
    ub_async = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      chk_both($sformatf("t5_fall_E%0d", k), (k < 5), (k >= 2 && k <= 4));
    end
    ub_async = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk_both($sformatf("t5_rerise_E%0d", k), (k >= 5), (k >= 2 && k <= 4));
    end

    settle("t3_pre_low", 1'b0);

    // Test 3: bounce 1,0,1,0 then hold 1; last 0->1 capture is edge 4, level rises on edge 9.
    for (int k = 0; k <= 11; k++) begin
      ub_async = (k < 4) ? ((k % 2) == 0) : 1'b1;
      tick();
      chk_both($sformatf("t3_A%0d", k), (k >= 9),
               (k == 2 || k == 4 || k == 6 || k == 7 || k == 8));
    end

    settle("t4_pre_low", 1'b0);

    // Test 4: three-cycle glitch; busy for 3 cycles, level untouched.
    for (int k = 0; k <= 9; k++) begin
      ub_async = (k < 3);
      tick();
      chk_both($sformatf("t4_G%0d", k), 1'b0, (k >= 2 && k <= 4));
    end

    settle("t6_pre_high", 1'b1);

    // Test 6: asynchronous reset while qualifying a fall.
    ub_async = 1'b0;
    repeat (3) tick();
    chk_both("t6_check_low", 1'b1, 1'b1);
    #2;
    rst_l    = 1'b0;
    ub_async = 1'b1;
    #1;
    chk_both("t6_async_reset", 1'b0, 1'b0);
    tick();
    chk_both("t6_held_reset", 1'b0, 1'b0);
    rst_l = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk_both($sformatf("t6_after_E%0d", k), (k >= 5), (k >= 2 && k <= 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
